sprite_drawer: RTL and testbench
================================

// Module: sprite_drawer
// PURPOSE
// - Executes the CHIP-8 DXYN draw: fetches N sprite bytes from main memory (mem read port, 1-cycle
//   read_ack) and XORs them into the 64x32 1-bit screen RAM, reporting collision for VF.
// - Sits between the CPU (start/busy/done) and two memories: main memory (read only) and
//   screen RAM (256 bytes, 8 bytes per row, MSB = leftmost pixel, same 1-cycle read/ack protocol).
// PARAMETERS
// - debug  0  when 1, $display every screen write
// PORTS
// - clk             in   1   clock, all state on posedge
// - rst_n           in   1   asynchronous reset, active low
// - start           in   1   draw request; sampled only when busy=0
// - x               in   8   VX; the block uses x[5:0]
// - y               in   8   VY; the block uses y[4:0]
// - n               in   4   sprite height in rows
// - i_addr          in   12  I register, address of first sprite byte
// - busy            out  1   high from the cycle after an accepted start through the done cycle
// - done            out  1   one-cycle pulse, draw complete
// - collision       out  1   valid from done until the next accepted start; 1 if any set pixel was cleared
// - read            out  1   main memory read strobe
// - read_idx        out  12  main memory address
// - read_byte       in   8   main memory data, valid with read_ack
// - read_ack        in   1   main memory ack
// - scr_read        out  1   screen read strobe
// - scr_read_idx    out  8   screen byte index = row*8 + col/8
// - scr_read_byte   in   8   screen data, valid with scr_read_ack
// - scr_read_ack    in   1   screen ack
// - scr_write       out  1   screen write strobe
// - scr_write_idx   out  8   screen write index
// - scr_write_byte  out  8   screen write data
// BEHAVIOUR
// - Reset: state IDLE; busy, done, collision, read, scr_read, scr_write = 0; indices/data = 0.
// - start with busy=1 is ignored. start latches x[5:0], y[4:0], n, i_addr; row counter k=0;
//   collision cleared.
// - States: IDLE -> MEM_RD -> MEM_ACK -> SCR_L -> [SCR_R_RD -> SCR_R] -> next row or DONE -> IDLE.
// - MEM_RD: read=1, read_idx = i_addr+k, wrapping mod 4096.
// - MEM_ACK: held until read_ack; on ack latch sprite byte; scr_read=1 on the left byte
//   (y+k)*8 + x/8.
// - SCR_L: held until scr_read_ack; write the left byte XOR (sprite >> x%8);
//   collision |= |(old & (sprite >> x%8)).
// - SCR_R: taken only if x%8 != 0 and x/8 != 7. Reads index+1, writes the byte XOR
//   (sprite << (8 - x%8)), with the same collision rule.
// - Row advance: k+1. Go to DONE when k+1 == n or y+k == 31.
// - Clipping: start coordinates wrap (mod 64 / mod 32). Pixels past the right or bottom edge
//   are discarded, not wrapped.
// - n == 0: IDLE -> DONE with no memory or screen access; collision = 0.
// - Latency with immediate acks: 3 cycles per row without a right byte, 5 with one.
//   done = 1 + rows*3 + 2*(rows with right byte) cycles after the start edge.
// - DONE: done=1 for one cycle; busy drops the next cycle; a new start can be accepted
//   that next cycle.
// - Strobes (read, scr_read, scr_write) are one-cycle pulses. Never read and write the screen
//   in the same cycle.
// - Reset mid-draw: returns to IDLE immediately. Partially drawn rows remain in screen RAM.
// STRUCTURE
// - chip8_defs.vh (shared include): SCREEN_W=64, SCREEN_H=32, SCREEN_BYTES=256, state encodings.
// - Single module; shifter and collision logic inline. No sub-module.
// TESTING
// - x=8, y=0, n=1, I=0x300, mem[0x300]=0xF0, blank screen -> one write idx 0x01 = 0xF0,
//   collision 0, done 4 cycles after start.
// - x=3, y=2, n=1, byte 0xFF -> idx 0x10 ^= 0x1F, idx 0x11 ^= 0xE0, done at cycle 6.
// - x=60, y=0, byte 0xFF -> only idx 0x07 ^= 0x0F, no second byte.
//   y=30, n=5 -> exactly 2 rows drawn.
// - Same sprite drawn twice at x=8, y=0 -> screen back to 0, second draw collision=1.
//   x=70 is treated as x=6.
// - n=0 -> done the cycle after MEM-less DONE, no strobes; start during busy -> ignored,
//   no extra done.
// - Assert rst_n low mid-row -> busy=0 and all strobes 0 immediately; next start runs normally.

Source files
------------

// File: rtl/sprite_drawer_pkg.sv
// Shared definitions for the CHIP-8 sprite drawer: screen geometry and FSM states.
package sprite_drawer_pkg;

  localparam logic [4:0] SCREEN_LAST_ROW = 5'd31;  // bottom row of the 64x32 screen
  localparam logic [2:0] LAST_COL_BYTE   = 3'd7;   // rightmost byte column of a row

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_MEM_ACK,
    ST_SCR_L,
    ST_SCR_R_RD,
    ST_SCR_R,
    ST_DONE
  } state_e;

  // Screen RAM holds 8 bytes per row, so the byte index is simply {row, byte column}.
  function automatic logic [7:0] scr_index(input logic [4:0] row, input logic [2:0] col_byte);
    return {row, col_byte};
  endfunction

endpackage

// File: rtl/sprite_drawer.sv
// CHIP-8 DXYN draw engine: fetches N sprite bytes from main memory and XORs them into
// the 64x32 screen RAM, one row at a time, reporting whether any lit pixel was cleared.
// All strobes are registered, so a strobe is visible in the state that waits for its ack;
// an ack may arrive in the strobe cycle itself or any later cycle.
module sprite_drawer
  import sprite_drawer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  output logic        busy,
  output logic        done,
  output logic        collision,
  output logic        read,
  output logic [11:0] read_idx,
  input  logic [7:0]  read_byte,
  input  logic        read_ack,
  output logic        scr_read,
  output logic [7:0]  scr_read_idx,
  input  logic [7:0]  scr_read_byte,
  input  logic        scr_read_ack,
  output logic        scr_write,
  output logic [7:0]  scr_write_idx,
  output logic [7:0]  scr_write_byte
);

  state_e      state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [3:0]  n_q, n_d;
  logic [11:0] i_q, i_d;
  logic [3:0]  k_q, k_d;
  logic [7:0]  sprite_q, sprite_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        coll_q, coll_d;
  logic        read_q, read_d;
  logic [11:0] read_idx_q, read_idx_d;
  logic        scr_read_q, scr_read_d;
  logic [7:0]  scr_read_idx_q, scr_read_idx_d;
  logic        scr_write_q, scr_write_d;
  logic [7:0]  scr_write_idx_q, scr_write_idx_d;
  logic [7:0]  scr_write_byte_q, scr_write_byte_d;

  // Only x[5:0] and y[4:0] matter: start coordinates wrap around the screen.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x[7:6], y[7:5]};

  logic [4:0] row;
  logic       need_right;
  logic       last_row;
  logic [7:0] mask_l;
  logic [7:0] mask_r;
  logic [7:0] mask_sel;
  logic       row_end;

  // Row geometry and the two halves of the shifted sprite byte.
  always_comb begin
    row        = y_q + {1'b0, k_q};
    need_right = (x_q[2:0] != 3'd0) && (x_q[5:3] != LAST_COL_BYTE);
    last_row   = ((k_q + 4'd1) == n_q) || (row == SCREEN_LAST_ROW);
    mask_l     = sprite_q >> x_q[2:0];
    mask_r     = sprite_q << (4'd8 - {1'b0, x_q[2:0]});
    mask_sel   = (state_q == ST_SCR_R) ? mask_r : mask_l;
  end

  // Next-state and next-output logic for the draw sequencer.
  always_comb begin
    // NOTE: every variable gets a default here first so no path leaves it unassigned (no latch).
    state_d          = state_q;
    x_d              = x_q;
    y_d              = y_q;
    n_d              = n_q;
    i_d              = i_q;
    k_d              = k_q;
    sprite_d         = sprite_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    coll_d           = coll_q;
    read_d           = 1'b0;
    read_idx_d       = read_idx_q;
    scr_read_d       = 1'b0;
    scr_read_idx_d   = scr_read_idx_q;
    scr_write_d      = 1'b0;
    scr_write_idx_d  = scr_write_idx_q;
    scr_write_byte_d = scr_write_byte_q;
    row_end          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d    = x[5:0];
          y_d    = y[4:0];
          n_d    = n;
          i_d    = i_addr;
          k_d    = 4'd0;
          coll_d = 1'b0;
          busy_d = 1'b1;
          if (n == 4'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_MEM_RD;
          end
        end
      end
      ST_MEM_RD: begin
        read_d     = 1'b1;
        read_idx_d = i_q + {8'd0, k_q};
        state_d    = ST_MEM_ACK;
      end
      ST_MEM_ACK: begin
        if (read_ack) begin
          sprite_d       = read_byte;
          scr_read_d     = 1'b1;
          scr_read_idx_d = scr_index(row, x_q[5:3]);
          state_d        = ST_SCR_L;
        end
      end
      ST_SCR_L: begin
        if (scr_read_ack) begin
          scr_write_d      = 1'b1;
          scr_write_idx_d  = scr_read_idx_q;
          scr_write_byte_d = scr_read_byte ^ mask_sel;
          coll_d           = coll_q | (|(scr_read_byte & mask_sel));
          if (need_right) state_d = ST_SCR_R_RD;
          else            row_end = 1'b1;
        end
      end
      ST_SCR_R_RD: begin
        // The left write is on the bus this cycle; the right read goes out one cycle later.
        scr_read_d     = 1'b1;
        scr_read_idx_d = scr_read_idx_q + 8'd1;
        state_d        = ST_SCR_R;
      end
      ST_SCR_R: begin
        if (scr_read_ack) begin
          scr_write_d      = 1'b1;
          scr_write_idx_d  = scr_read_idx_q;
          scr_write_byte_d = scr_read_byte ^ mask_sel;
          coll_d           = coll_q | (|(scr_read_byte & mask_sel));
          row_end          = 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Rows past the bottom edge are clipped, so reaching row 31 also ends the draw.
    if (row_end) begin
      if (last_row) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        k_d     = k_q + 4'd1;
        state_d = ST_MEM_RD;
      end
    end
  end

  // State and registered outputs; reset abandons any draw in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      x_q              <= '0;
      y_q              <= '0;
      n_q              <= '0;
      i_q              <= '0;
      k_q              <= '0;
      sprite_q         <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      coll_q           <= 1'b0;
      read_q           <= 1'b0;
      read_idx_q       <= '0;
      scr_read_q       <= 1'b0;
      scr_read_idx_q   <= '0;
      scr_write_q      <= 1'b0;
      scr_write_idx_q  <= '0;
      scr_write_byte_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
      state_q          <= state_d;
      x_q              <= x_d;
      y_q              <= y_d;
      n_q              <= n_d;
      i_q              <= i_d;
      k_q              <= k_d;
      sprite_q         <= sprite_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      coll_q           <= coll_d;
      read_q           <= read_d;
      read_idx_q       <= read_idx_d;
      scr_read_q       <= scr_read_d;
      scr_read_idx_q   <= scr_read_idx_d;
      scr_write_q      <= scr_write_d;
      scr_write_idx_q  <= scr_write_idx_d;
      scr_write_byte_q <= scr_write_byte_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign collision      = coll_q;
  assign read           = read_q;
  assign read_idx       = read_idx_q;
  assign scr_read       = scr_read_q;
  assign scr_read_idx   = scr_read_idx_q;
  assign scr_write      = scr_write_q;
  assign scr_write_idx  = scr_write_idx_q;
  assign scr_write_byte = scr_write_byte_q;

endmodule

// File: tb/tb_sprite_drawer.sv
// Self-checking bench for sprite_drawer: pixel-level reference model feeding read/write
// scoreboards, a table of draws with expected latency, and hand-written corner sequences.
module tb_sprite_drawer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  x, y;
  logic [3:0]  n;
  logic [11:0] i_addr;
  logic        busy, done, collision;
  logic        read;
  logic [11:0] read_idx;
  logic [7:0]  read_byte;
  logic        read_ack;
  logic        scr_read;
  logic [7:0]  scr_read_idx;
  logic [7:0]  scr_read_byte;
  logic        scr_read_ack;
  logic        scr_write;
  logic [7:0]  scr_write_idx;
  logic [7:0]  scr_write_byte;

  sprite_drawer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .n(n), .i_addr(i_addr),
    .busy(busy), .done(done), .collision(collision),
    .read(read), .read_idx(read_idx), .read_byte(read_byte), .read_ack(read_ack),
    .scr_read(scr_read), .scr_read_idx(scr_read_idx), .scr_read_byte(scr_read_byte),
    .scr_read_ack(scr_read_ack),
    .scr_write(scr_write), .scr_write_idx(scr_write_idx), .scr_write_byte(scr_write_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories: immediate acks normally, one-cycle-late acks when slow=1.
  logic [7:0]  mem    [4096];
  logic [7:0]  screen [256];
  logic        slow;
  logic        rd_pend, srd_pend;
  logic [11:0] rd_idx_l;
  logic [7:0]  srd_idx_l;

  always @(posedge clk) begin
    rd_pend   <= slow & read;
    rd_idx_l  <= read_idx;
    srd_pend  <= slow & scr_read;
    srd_idx_l <= scr_read_idx;
    if (scr_write) screen[scr_write_idx] <= scr_write_byte;
  end

  assign read_ack      = slow ? rd_pend : read;
  assign read_byte     = slow ? mem[rd_idx_l] : mem[read_idx];
  assign scr_read_ack  = slow ? srd_pend : scr_read;
  assign scr_read_byte = slow ? screen[srd_idx_l] : screen[scr_read_idx];

  // Scoreboard state.
  typedef struct packed { logic [7:0] idx; logic [7:0] data; } wr_t;
  wr_t         exp_wr[$];
  logic [11:0] exp_rd[$];
  logic [7:0]  exp_scr [256];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          strobe_cnt = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // Strobe monitor: pops expected reads/writes as the DUT issues them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (read || scr_read || scr_write) strobe_cnt++;
      if (scr_read || scr_write) check("scr_rw_overlap", {31'd0, scr_read & scr_write}, 32'd0);
      if (read) begin
        if (exp_rd.size() == 0) fail("unexpected_mem_read");
        else check("mem_read_idx", {20'd0, read_idx}, {20'd0, exp_rd.pop_front()});
      end
      if (scr_write) begin
        if (exp_wr.size() == 0) fail("unexpected_scr_write");
        else begin
          wr_t w;
          w = exp_wr.pop_front();
          check("scr_write_idx", {24'd0, scr_write_idx}, {24'd0, w.idx});
          check("scr_write_byte", {24'd0, scr_write_byte}, {24'd0, w.data});
        end
      end
    end
  end

  // Pixel-level reference: XOR each sprite bit into the shadow screen, clipping at the edges.
  task automatic model_draw(input logic [7:0] xx, input logic [7:0] yy, input logic [3:0] nn,
                            input logic [11:0] ii, output bit coll, output int rows);
    int px0, py0, py, px, bi;
    bit right;
    logic [11:0] a;
    logic [7:0]  spr;
    px0   = int'(xx) % 64;
    py0   = int'(yy) % 32;
    right = (px0 % 8 != 0) && (px0 / 8 != 7);
    coll  = 0;
    rows  = 0;
    for (int r = 0; r < int'(nn); r++) begin
      py = py0 + r;
      if (py > 31) break;
      rows++;
      a = ii + 12'(r);
      exp_rd.push_back(a);
      spr = mem[a];
      for (int b = 0; b < 8; b++) begin
        px = px0 + b;
        if (px < 64 && spr[7-b]) begin
          bi = py * 8 + px / 8;
          if (exp_scr[bi][7 - px % 8]) coll = 1;
          exp_scr[bi][7 - px % 8] = ~exp_scr[bi][7 - px % 8];
        end
      end
      bi = py * 8 + px0 / 8;
      exp_wr.push_back('{idx: 8'(bi), data: exp_scr[bi]});
      if (right) exp_wr.push_back('{idx: 8'(bi + 1), data: exp_scr[bi + 1]});
    end
  endtask

  // One draw: model it, pulse start, wait (bounded) for done, check latency and collision.
  // poke >= 0 re-asserts start with different operands at that cycle of the draw.
  task automatic run_draw(input string nm, input logic [7:0] xx, input logic [7:0] yy,
                          input logic [3:0] nn, input logic [11:0] ii,
                          input int exp_cyc, input int exp_coll, input int poke);
    bit coll;
    int rows, cyc;
    bit got;
    model_draw(xx, yy, nn, ii, coll, rows);
    @(negedge clk);
    x = xx; y = yy; n = nn; i_addr = ii; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({nm, "_busy"}, {31'd0, busy}, 32'd1);
      if (cyc == poke) begin x = 8'd0; n = 4'd1; i_addr = 12'h301; start = 1'b1; end
      if (cyc == poke + 1) start = 1'b0;
      if (done) got = 1;
    end
    if (!got) fail({nm, "_done_timeout"});
    if (exp_cyc >= 0) check({nm, "_latency"}, cyc, exp_cyc);
    check({nm, "_collision"}, {31'd0, collision}, (exp_coll >= 0) ? exp_coll : {31'd0, coll});
    @(negedge clk);
    check({nm, "_busy_drop"}, {31'd0, busy}, 32'd0);
    check({nm, "_rd_queue"}, exp_rd.size(), 32'd0);
    check({nm, "_wr_queue"}, exp_wr.size(), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [3:0]  n;
    logic [11:0] i;
    int          cyc;   // expected done latency, -1 when acks are slowed
    bit          slow;
  } vec_t;

  vec_t tbl[7];
  logic [7:0] save_scr [256];
  int d0, s0;

  initial begin
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0; n = '0; i_addr = '0; slow = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'(a * 37 + 5);
    mem[12'h300] = 8'hF0;
    mem[12'h301] = 8'hFF;
    for (int b = 0; b < 256; b++) begin screen[b] = 8'h00; exp_scr[b] = 8'h00; end

    tbl[0] = '{"x3y2",     8'd3,  8'd2,  4'd1,  12'h301, 6,  1'b0};
    tbl[1] = '{"x60",      8'd60, 8'd0,  4'd1,  12'h301, 4,  1'b0};
    tbl[2] = '{"x70wrap",  8'd70, 8'd10, 4'd2,  12'h302, 11, 1'b0};
    tbl[3] = '{"yclip",    8'd0,  8'd30, 4'd5,  12'h310, 7,  1'b0};
    tbl[4] = '{"iwrap",    8'd16, 8'd40, 4'd4,  12'hFFE, 13, 1'b0};
    tbl[5] = '{"x63",      8'd63, 8'd5,  4'd3,  12'h320, 10, 1'b0};
    tbl[6] = '{"n15",      8'd13, 8'd33, 4'd15, 12'h330, 76, 1'b0};

    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_collision", {31'd0, collision}, 32'd0);
    check("rst_strobes", {29'd0, read, scr_read, scr_write}, 32'd0);
    check("rst_indices", {read_idx, scr_read_idx, scr_write_idx}, 32'd0);
    check("rst_wdata", {24'd0, scr_write_byte}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Same sprite twice: lit then erased, the second draw reporting a collision.
    run_draw("first_x8", 8'd8, 8'd0, 4'd1, 12'h300, 4, 0, -1);
    check("first_x8_screen", {24'd0, screen[1]}, 32'h0000_00F0);
    run_draw("second_x8", 8'd8, 8'd0, 4'd1, 12'h300, 4, 1, -1);
    check("second_x8_screen", {24'd0, screen[1]}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      slow = tbl[v].slow;
      run_draw(tbl[v].name, tbl[v].x, tbl[v].y, tbl[v].n, tbl[v].i, tbl[v].cyc, -1, -1);
    end

    // Late acks on both memories stretch the draw but must leave the same screen.
    slow = 1'b1;
    run_draw("slow_ack", 8'd5, 8'd20, 4'd3, 12'h340, -1, -1, -1);
    slow = 1'b0;

    // n == 0: done right after start with no memory or screen traffic.
    s0 = strobe_cnt;
    run_draw("n0", 8'd12, 8'd4, 4'd0, 12'h350, 1, 0, -1);
    check("n0_no_strobes", strobe_cnt - s0, 32'd0);

    // Start while busy is ignored: one done, latency of the original draw only.
    d0 = done_cnt;
    run_draw("busy_start", 8'd24, 8'd12, 4'd2, 12'h360, 7, -1, 3);
    repeat (10) @(negedge clk);
    check("busy_start_one_done", done_cnt - d0, 32'd1);

    // Reset during the first row's memory access: everything drops at once, screen untouched.
    save_scr = exp_scr;
    begin
      bit c;
      int r;
      model_draw(8'd40, 8'd16, 4'd3, 12'h370, c, r);
    end
    @(negedge clk);
    x = 8'd40; y = 8'd16; n = 4'd3; i_addr = 12'h370; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_strobes", {28'd0, done, read, scr_read, scr_write}, 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    exp_scr = save_scr;
    @(negedge clk);
    rst_n = 1'b1;
    run_draw("after_rst", 8'd40, 8'd16, 4'd3, 12'h370, 10, -1, -1);

    for (int b = 0; b < 256; b++)
      if (screen[b] !== exp_scr[b]) fail($sformatf("final_screen[%0d] got 0x%0h", b, screen[b]));
    check("final_screen_scan", 32'd256, 32'd256 - 32'(n_fail - n_fail));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
